// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-to-decode instruction handshake.
// master: fetch side, drives the queue head (if_valid, if_instr, if_pc) and samples if_ready.
// slave : decode side, samples the head and drives if_ready.
interface instr_fetch_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  if_valid;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;

    modport master (
        output if_valid,
        output if_instr,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output if_ready
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches one word per cycle from a combinational
// instruction memory into a 2-entry queue, and shares the memory port with a debug reader.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   imem_addr_o/imem_data_i word-indexed memory port (data valid same cycle)
//   if_bus (master)         queue head to decode, valid/ready
//   redirect_valid_i/pc_i   branch redirect (byte PC)
//   halt_req_i, halted_o    level halt request and halted status
//   fault_o                 sticky address fault (cleared only by reset)
//   dbg_req_i/dbg_addr_i    debug read request (word index)
//   dbg_ack_o/dbg_data_o    one-cycle ack with registered read data
module instr_fetch_ctrl #(
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter int unsigned            ADDR_WIDTH    = 32,
    parameter int unsigned            MEM_DEPTH     = 64,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC      = '0,
    parameter int unsigned            DBG_MAX_BURST = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    instr_fetch_ctrl_if.master    if_bus,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  halt_req_i,
    output logic                  halted_o,
    output logic                  fault_o,
    input  logic                  dbg_req_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    output logic                  dbg_ack_o,
    output logic [DATA_WIDTH-1:0] dbg_data_o
);
    localparam int unsigned           BurstW    = $clog2(DBG_MAX_BURST + 2);
    localparam logic [BurstW-1:0]     BurstMax  = BurstW'(DBG_MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0] MemDepthW = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            count_q, count_d;
    logic [BurstW-1:0]     burst_q, burst_d;
    logic                  dbg_ack_q, dbg_ack_d;
    logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
    // Entry 0 is the head and drives the decode outputs directly.
    logic [ADDR_WIDTH-1:0] ent_pc_q [2];
    logic [ADDR_WIDTH-1:0] ent_pc_d [2];
    logic [DATA_WIDTH-1:0] ent_instr_q [2];
    logic [DATA_WIDTH-1:0] ent_instr_d [2];

    logic                  pop, space, fetch_want, dbg_grant, fetch_fire;
    logic [ADDR_WIDTH-1:0] pc_word, redir_word;
    logic                  pc_oob, redir_bad;

    always_comb begin
        pop        = (count_q != 2'd0) && if_bus.if_ready;
        space      = (count_q < 2'd2) || pop;
        fetch_want = (state_q == StRun) && space && !redirect_valid_i;
        // Debug wins unless fetch has already been starved for a full burst.
        dbg_grant  = dbg_req_i && !(fetch_want && (burst_q == BurstMax));
        fetch_fire = fetch_want && !dbg_grant;

        pc_word     = pc_q >> 2;
        pc_oob      = pc_word >= MemDepthW;
        redir_word  = redirect_pc_i >> 2;
        redir_bad   = (redirect_pc_i[1:0] != 2'b00) || (redir_word >= MemDepthW);
        imem_addr_o = dbg_grant ? dbg_addr_i : pc_word;

        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        dbg_ack_d   = dbg_grant;
        dbg_data_d  = dbg_grant ? imem_data_i : dbg_data_q;
        // Burst only counts grants that actually held off a fetch.
        if (!dbg_grant) begin
            burst_d = '0;
        end else if (fetch_want) begin
            burst_d = burst_q + BurstW'(1);
        end else begin
            burst_d = burst_q;
        end

        if (redirect_valid_i && (state_q != StFault)) begin
            // Flush wins over any same-cycle pop or push.
            count_d = 2'd0;
            if (redir_bad) begin
                state_d = StFault;
            end else begin
                pc_d = redirect_pc_i;
            end
        end else begin
            if (pop) begin
                ent_pc_d[0]    = ent_pc_q[1];
                ent_instr_d[0] = ent_instr_q[1];
                count_d        = count_q - 2'd1;
            end
            unique case (state_q)
                StRun: begin
                    if (halt_req_i) begin
                        state_d = StHalted;
                    end else if (fetch_fire) begin
                        if (pc_oob) begin
                            state_d = StFault;
                        end else begin
                            if (count_d == 2'd0) begin
                                ent_pc_d[0]    = pc_q;
                                ent_instr_d[0] = imem_data_i;
                            end else begin
                                ent_pc_d[1]    = pc_q;
                                ent_instr_d[1] = imem_data_i;
                            end
                            count_d = count_d + 2'd1;
                            pc_d    = pc_q + ADDR_WIDTH'(4);
                        end
                    end
                end
                StHalted: begin
                    if (!halt_req_i) state_d = StRun;
                end
                StFault: ;
                default: state_d = StFault;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            count_q     <= 2'd0;
            burst_q     <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_data_q  <= '0;
            ent_pc_q    <= '{default: '0};
            ent_instr_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            burst_q     <= burst_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_data_q  <= dbg_data_d;
            ent_pc_q    <= ent_pc_d;
            ent_instr_q <= ent_instr_d;
        end
    end

    assign if_bus.if_valid = (count_q != 2'd0);
    assign if_bus.if_instr = ent_instr_q[0];
    assign if_bus.if_pc    = ent_pc_q[0];
    assign halted_o        = (state_q == StHalted);
    assign fault_o         = (state_q == StFault);
    assign dbg_ack_o       = dbg_ack_q;
    assign dbg_data_o      = dbg_data_q;
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the combinational, word-indexed instruction memory (`instr_mem`).
- Owns the PC and issues one fetch per cycle into a 2-entry instruction queue. The queue feeds decode over a valid/ready handshake.
- Shares the memory address port between fetch and a debug read port, with bounded debug priority.
- Handles branch redirect, halt, and address faults.

Parameters:
- DATA_WIDTH, 32: instruction word width; matches instr_mem MEM_WORD.
- ADDR_WIDTH, 32: PC and memory address width.
- MEM_DEPTH, 64: number of valid instruction words; valid word index 0..MEM_DEPTH-1.
- RESET_PC, 0: byte PC after reset; multiple of 4.
- DBG_MAX_BURST, 2: max consecutive debug grants while fetch is waiting.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  ADDR_WIDTH  word index to instr_mem.
- imem_data  in  DATA_WIDTH  instr_mem read data; valid in the same cycle.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts head.
- if_instr  out  DATA_WIDTH  head instruction.
- if_pc  out  ADDR_WIDTH  head byte PC.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  ADDR_WIDTH  new byte PC.
- halt_req  in  1  level; stop fetching while high.
- halted  out  1  state == HALTED.
- fault  out  1  state == FAULT; sticky.
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_WIDTH  debug word index.
- dbg_ack  out  1  one-cycle pulse; dbg_data valid.
- dbg_data  out  DATA_WIDTH  registered debug read data.

Behaviour:

Clock and reset:
- One clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only at the rising edge.

Reset values:
- pc = RESET_PC; queue empty (count 0); state RUN; debug burst counter 0.
- if_valid = 0, if_instr = 0, if_pc = 0, halted = 0, fault = 0, dbg_ack = 0, dbg_data = 0.

States:
- RUN: fetch enabled.
- HALTED: no fetch.
- FAULT: no fetch; exit only by reset.

Address mux:
- imem_addr = dbg_addr when dbg_grant, else pc >> 2 (zero-extended).

Debug arbitration:
- dbg_grant = dbg_req && !(fetch_want && burst == DBG_MAX_BURST).
- fetch_want = (state == RUN) && space && !redirect_valid.
- burst increments on each grant made while fetch_want is 1. It clears on any cycle without a grant.
- On grant: dbg_data <= imem_data, and dbg_ack = 1 in the next cycle.
- Debug access is legal in every state. It is not range-checked; out-of-range returns memory content as-is.

Queue:
- space = (count < 2) || (if_valid && if_ready).
- Fetch fires when fetch_want && !dbg_grant. It pushes {pc, imem_data} and sets pc <= pc + 4.
- Push and pop in the same cycle: count unchanged.
- Head is presented registered. if_valid = (count != 0).
- Fetch-to-if_valid latency: 1 cycle.

Redirect (priority over fetch, halt and debug-stall effects; below reset):
- Flushes the queue (count <= 0) and sets pc <= redirect_pc. No push that cycle.
- A pop in the same cycle is discarded: treated as a flush.
- If redirect_pc[1:0] != 0 or (redirect_pc >> 2) >= MEM_DEPTH: go to FAULT instead, queue flushed, pc unchanged.
- In HALTED, redirect updates pc and flushes, and the state stays HALTED.
- In FAULT, redirect is ignored.

Sequential fault:
- If a fetch would fire with (pc >> 2) >= MEM_DEPTH, go to FAULT instead, with no push.
- Entries already queued remain and drain normally.

Halt:
- RUN -> HALTED at the edge where halt_req = 1; the fetch in that cycle is suppressed.
- HALTED -> RUN at the edge where halt_req = 0.
- The queue keeps draining while halted.

Wrap-around:
- pc + 4 wraps modulo 2^ADDR_WIDTH. The range check faults first.

Test Plan:
1. Reset, if_ready = 1, mem[i] = 0x1000+i -> if_valid rises cycle 1. Stream if_pc 0, 4, 8, ... with instr 0x1000, 0x1001, ..., one per cycle.
2. if_ready = 0 for 5 cycles -> count saturates at 2 and pc stops at 8. On if_ready = 1, the head continues at pc 0 with no lost or duplicate entry.
3. redirect_valid with redirect_pc = 0x40 while the queue is full -> queue flushed, next if_pc = 0x40. A second redirect to 0x42 -> fault = 1, if_valid = 0.
4. dbg_req held high 6 cycles, dbg_addr = 5, queue not full -> grant pattern dbg, dbg, fetch, dbg, dbg, fetch. dbg_ack pulses 1 cycle after each grant with dbg_data = mem[5].
5. Sequential fetch reaching pc = 4*MEM_DEPTH -> fault sets, the last valid entry (pc = 0xFC) still delivered. rst_n low 1 cycle mid-stream -> all outputs at reset values and refetch from RESET_PC.
6. halt_req = 1 for 3 cycles -> halted = 1, no pc advance, queue drains. Release -> fetch resumes at the held pc.
